// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// memory-wait FSM states and the load encoding of ResultSrcE.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    MEM_IDLE,
    MEM_WAIT
  } mem_state_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // The Memory stage holds the younger value, so it wins over Writeback.
  function automatic fwd_sel_t fwd_select(input logic mem_hit, input logic wb_hit);
    if (mem_hit)     return FWD_MEM;
    else if (wb_hit) return FWD_WB;
    else             return FWD_RF;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  output logic [CNT_WIDTH-1:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i)
      count_o <= '0;
    else if (en_i && (count_o != '1))
      count_o <= count_o + CNT_WIDTH'(1);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: forwarding, stall/flush generation,
// multi-cycle data-memory wait tracking and saturating perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REGISTER_ADDRESS_WIDTH = 5,
  parameter int CNT_WIDTH              = 32,
  parameter int MEM_TIMEOUT            = 64
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE_i,
  input  logic [1:0]                        ResultSrcE_i,
  input  logic                              PCSrcE_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM_i,
  input  logic                              RegWriteM_i,
  input  logic                              MemReqM_i,
  input  logic                              MemReadyM_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW_i,
  input  logic                              RegWriteW_i,
  output logic                              StallF_o,
  output logic                              StallD_o,
  output logic                              StallE_o,
  output logic                              StallM_o,
  output logic                              FlushD_o,
  output logic                              FlushE_o,
  output logic                              FlushW_o,
  output logic [1:0]                        ForwardAE_o,
  output logic [1:0]                        ForwardBE_o,
  output logic [CNT_WIDTH-1:0]              StallCycles_o,
  output logic [CNT_WIDTH-1:0]              FlushCount_o,
  output logic                              MemTimeout_o
);

  localparam int              WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  logic mem_hit_a, wb_hit_a, mem_hit_b, wb_hit_b;
  logic lw_stall, mem_stall;

  assign mem_hit_a = RegWriteM_i && (RdM_i == Rs1E_i) && (RdM_i != '0);
  assign wb_hit_a  = RegWriteW_i && (RdW_i == Rs1E_i) && (RdW_i != '0);
  assign mem_hit_b = RegWriteM_i && (RdM_i == Rs2E_i) && (RdM_i != '0);
  assign wb_hit_b  = RegWriteW_i && (RdW_i == Rs2E_i) && (RdW_i != '0);

  assign ForwardAE_o = fwd_select(mem_hit_a, wb_hit_a);
  assign ForwardBE_o = fwd_select(mem_hit_b, wb_hit_b);

  assign lw_stall  = (ResultSrcE_i == RESULT_SRC_LOAD) && (RdE_i != '0) &&
                     ((Rs1D_i == RdE_i) || (Rs2D_i == RdE_i));
  assign mem_stall = MemReqM_i && !MemReadyM_i;

  // A memory wait freezes the whole front of the pipe; branch and load-use
  // hazards are simply ignored until the access completes.
  always_comb begin
    StallF_o = 1'b0;
    StallD_o = 1'b0;
    StallE_o = 1'b0;
    StallM_o = 1'b0;
    FlushD_o = 1'b0;
    FlushE_o = 1'b0;
    FlushW_o = 1'b0;
    if (mem_stall) begin
      StallF_o = 1'b1;
      StallD_o = 1'b1;
      StallE_o = 1'b1;
      StallM_o = 1'b1;
      FlushW_o = 1'b1;
    end else begin
      StallF_o = lw_stall && !PCSrcE_i;
      StallD_o = lw_stall && !PCSrcE_i;
      FlushD_o = PCSrcE_i;
      FlushE_o = PCSrcE_i || lw_stall;
    end
  end

  mem_state_t        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, timeout_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= MEM_IDLE;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  // The wait counter holds the number of stalled cycles already spent; once
  // it has saturated, any further stalled cycle trips the sticky timeout.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    case (state_q)
      MEM_IDLE: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!MemReqM_i || MemReadyM_i) begin
          state_d = MEM_IDLE;
        end else if (wait_q == WAIT_MAX) begin
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  assign MemTimeout_o = timeout_q;

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (StallF_o || StallD_o || StallE_o || StallM_o),
    .count_o (StallCycles_o)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (PCSrcE_i && !mem_stall),
    .count_o (FlushCount_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed spec scenarios followed by randomized traffic, all checked against
// a cycle-level behavioural model of the hazard controller.
module tb_hazard_ctrl;

  localparam int RAW     = 5;
  localparam int CNT_W   = 8;
  localparam int MEM_TO  = 64;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [RAW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]     ResultSrcE;
  logic           PCSrcE, RegWriteM, MemReq, MemReady, RegWriteW;

  logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
  logic [1:0]       ForwardAE, ForwardBE;
  logic [CNT_W-1:0] StallCycles, FlushCount;

  hazard_ctrl #(
    .REGISTER_ADDRESS_WIDTH(RAW),
    .CNT_WIDTH             (CNT_W),
    .MEM_TIMEOUT           (MEM_TO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .Rs1D_i       (Rs1D),
    .Rs2D_i       (Rs2D),
    .Rs1E_i       (Rs1E),
    .Rs2E_i       (Rs2E),
    .RdE_i        (RdE),
    .ResultSrcE_i (ResultSrcE),
    .PCSrcE_i     (PCSrcE),
    .RdM_i        (RdM),
    .RegWriteM_i  (RegWriteM),
    .MemReqM_i    (MemReq),
    .MemReadyM_i  (MemReady),
    .RdW_i        (RdW),
    .RegWriteW_i  (RegWriteW),
    .StallF_o     (StallF),
    .StallD_o     (StallD),
    .StallE_o     (StallE),
    .StallM_o     (StallM),
    .FlushD_o     (FlushD),
    .FlushE_o     (FlushE),
    .FlushW_o     (FlushW),
    .ForwardAE_o  (ForwardAE),
    .ForwardBE_o  (ForwardBE),
    .StallCycles_o(StallCycles),
    .FlushCount_o (FlushCount),
    .MemTimeout_o (MemTimeout)
  );

  int compared   = 0;
  int mismatched = 0;

  // Model state: length of the current run of stalled memory cycles, counters.
  int runLen      = 0;
  int expStallCnt = 0;
  int expFlushCnt = 0;
  int expTimeout  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int fwdModel(input logic [RAW-1:0] rs);
    if (RegWriteM && RdM == rs && RdM != 0) return 2;
    if (RegWriteW && RdW == rs && RdW != 0) return 1;
    return 0;
  endfunction

  function automatic bit lwModel();
    return (ResultSrcE == 2'b01) && (RdE != 0) && (Rs1D == RdE || Rs2D == RdE);
  endfunction

  function automatic bit memStallModel();
    return MemReq && !MemReady;
  endfunction

  task automatic checkAll();
    bit lw, ms, pc;
    lw = lwModel();
    ms = memStallModel();
    pc = PCSrcE;
    checkOutput("ForwardAE", 32'(ForwardAE), fwdModel(Rs1E));
    checkOutput("ForwardBE", 32'(ForwardBE), fwdModel(Rs2E));
    checkOutput("StallF", 32'(StallF), ms ? 1 : 32'(lw && !pc));
    checkOutput("StallD", 32'(StallD), ms ? 1 : 32'(lw && !pc));
    checkOutput("StallE", 32'(StallE), 32'(ms));
    checkOutput("StallM", 32'(StallM), 32'(ms));
    checkOutput("FlushD", 32'(FlushD), 32'(!ms && pc));
    checkOutput("FlushE", 32'(FlushE), 32'(!ms && (pc || lw)));
    checkOutput("FlushW", 32'(FlushW), 32'(ms));
    checkOutput("StallCycles", 32'(StallCycles), expStallCnt);
    checkOutput("FlushCount", 32'(FlushCount), expFlushCnt);
    checkOutput("MemTimeout", 32'(MemTimeout), expTimeout);
  endtask

  task automatic updateModel();
    bit lw, ms;
    lw = lwModel();
    ms = memStallModel();
    if (rst) begin
      runLen = 0; expStallCnt = 0; expFlushCnt = 0; expTimeout = 0;
    end else begin
      if ((ms || (lw && !PCSrcE)) && expStallCnt < CNT_MAX) expStallCnt++;
      if (PCSrcE && !ms && expFlushCnt < CNT_MAX) expFlushCnt++;
      if (ms) begin
        if (runLen >= MEM_TO) expTimeout = 1;
        runLen++;
      end else begin
        runLen = 0;
      end
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic applyStimulus();
    #1;
    checkAll();
    @(posedge clk);
    updateModel();
    @(negedge clk);
  endtask

  task automatic clearInputs();
    rst = 1'b0;
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    ResultSrcE = 2'b00; PCSrcE = 1'b0; RegWriteM = 1'b0; MemReq = 1'b0;
    MemReady = 1'b0; RegWriteW = 1'b0;
  endtask

  initial begin
    clearInputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    applyStimulus();
    rst = 1'b0;

    // Forwarding priority
    RegWriteM = 1'b1; RdM = 5; Rs1E = 5; RegWriteW = 1'b1; RdW = 5;
    #1 checkOutput("t1_fwdMem", 32'(ForwardAE), 2);
    applyStimulus();
    RdM = 0;
    #1 checkOutput("t1_fwdWb", 32'(ForwardAE), 1);
    applyStimulus();
    RdW = 0;
    #1 checkOutput("t1_fwdRf", 32'(ForwardAE), 0);
    applyStimulus();
    clearInputs();

    // Load-use stall, then a load to x0
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    applyStimulus();
    checkOutput("t2_stallCnt", 32'(StallCycles), 1);
    RdE = 0; Rs2D = 0;
    #1 checkOutput("t2_x0NoStall", 32'(StallF), 0);
    applyStimulus();

    // Branch overrides load-use
    ResultSrcE = 2'b01; RdE = 7; Rs1D = 7; PCSrcE = 1'b1;
    applyStimulus();
    checkOutput("t3_flushCnt", 32'(FlushCount), 1);
    clearInputs();

    // Three-cycle memory wait
    MemReq = 1'b1;
    repeat (3) applyStimulus();
    MemReady = 1'b1;
    #1 checkOutput("t4_readyNoStall", 32'(StallM), 0);
    applyStimulus();
    checkOutput("t4_stallCnt", 32'(StallCycles), 4);
    clearInputs();

    // Branch held during a wait, acted on in the ready cycle
    MemReq = 1'b1; PCSrcE = 1'b1;
    repeat (2) applyStimulus();
    checkOutput("t5_noFlushYet", 32'(FlushCount), 1);
    MemReady = 1'b1;
    applyStimulus();
    checkOutput("t5_flushCnt", 32'(FlushCount), 2);
    clearInputs();

    // Timeout and reset mid-wait
    MemReq = 1'b1;
    repeat (MEM_TO + 2) applyStimulus();
    MemReady = 1'b1;
    applyStimulus();
    clearInputs();
    repeat (2) applyStimulus();
    checkOutput("t6_timeoutSticky", 32'(MemTimeout), 1);
    MemReq = 1'b1;
    repeat (2) applyStimulus();
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    checkOutput("t6_rstTimeout", 32'(MemTimeout), 0);
    checkOutput("t6_rstStallCnt", 32'(StallCycles), 0);
    clearInputs();
    applyStimulus();

    // Randomized traffic with a narrow register range to provoke matches
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      Rs1D       = RAW'($urandom_range(0, 3));
      Rs2D       = RAW'($urandom_range(0, 3));
      Rs1E       = RAW'($urandom_range(0, 3));
      Rs2E       = RAW'($urandom_range(0, 3));
      RdE        = RAW'($urandom_range(0, 3));
      RdM        = RAW'($urandom_range(0, 3));
      RdW        = RAW'($urandom_range(0, 3));
      ResultSrcE = 2'($urandom_range(0, 3));
      PCSrcE     = ($urandom_range(0, 4) == 0);
      RegWriteM  = ($urandom_range(0, 1) == 1);
      RegWriteW  = ($urandom_range(0, 1) == 1);
      MemReq     = ($urandom_range(0, 2) == 0);
      MemReady   = ($urandom_range(0, 9) < 4);
      applyStimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
